// File: rtl/dm_arbiter_if.sv
// Data-memory arbitration bus: CPU requester, debug requester and the
// single-port synchronous memory, bundled so the arbiter takes one port.
// The slave modport is the arbiter's view; the master modport is the view
// of whatever sits around it (requesters plus the memory macro).
interface dm_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 32
);

  // CPU memory-stage requester
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt;
  logic          cpu_rvalid;
  logic          cpu_stall;
  logic [DW-1:0] cpu_rdata;

  // Debug / dump requester
  logic          dbg_req;
  logic          dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_gnt;
  logic          dbg_rvalid;
  logic [DW-1:0] dbg_rdata;

  // Single-port synchronous memory; read data arrives the cycle after the
  // enable
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_stall, cpu_rdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_stall, cpu_rdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/dm_arbiter.sv
// Two-requester arbiter in front of a single-port data memory.
// The CPU normally owns priority; a debug requester that has waited STARVE
// cycles is promoted and may then take up to DBG_MAX grants while the CPU
// is waiting. Grants are combinational so a lone requester is served with
// no added latency; read returns are steered back to the requester that
// issued them one cycle later.
module dm_arbiter #(
  parameter int AW      = 10,
  parameter int DW      = 32,
  parameter int STARVE  = 8,
  parameter int DBG_MAX = 4
) (
  input logic        clk,
  input logic        rst,
  dm_arbiter_if.slave bus
);

  localparam int WCW = (STARVE  > 1) ? $clog2(STARVE + 1)  : 1;
  localparam int BCW = (DBG_MAX > 1) ? $clog2(DBG_MAX + 1) : 1;

  localparam logic [WCW-1:0] WAIT_LAST = WCW'(STARVE - 1);
  localparam logic [BCW-1:0] BURST_MAX = BCW'(DBG_MAX);

  typedef enum logic {
    CPU_PRI = 1'b0,
    DBG_PRI = 1'b1
  } pri_e;

  pri_e           state_q, state_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic [BCW-1:0] burst_cnt_q, burst_cnt_d;
  logic           rd_cpu_q, rd_cpu_d;
  logic           rd_dbg_q, rd_dbg_d;

  logic           cpu_gnt;
  logic           dbg_gnt;
  logic           dbg_waiting;
  logic           mem_we_d;
  logic [AW-1:0]  mem_addr_d;
  logic [DW-1:0]  mem_wdata_d;

  // Pick at most one winner: a lone requester always wins, a contest goes to
  // whoever currently owns priority, and nothing is granted while in reset.
  always_comb begin
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (rst) begin
      if (bus.cpu_req && bus.dbg_req) begin
        if (state_q == DBG_PRI) begin
          dbg_gnt = 1'b1;
        end else begin
          cpu_gnt = 1'b1;
        end
      end else begin
        cpu_gnt = bus.cpu_req;
        dbg_gnt = bus.dbg_req;
      end
    end
  end

  // Steer the winner's command onto the memory port; idle port is all zero.
  always_comb begin
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    if (cpu_gnt) begin
      mem_we_d    = bus.cpu_we;
      mem_addr_d  = bus.cpu_addr;
      mem_wdata_d = bus.cpu_wdata;
    end else if (dbg_gnt) begin
      mem_we_d    = bus.dbg_we;
      mem_addr_d  = bus.dbg_addr;
      mem_wdata_d = bus.dbg_wdata;
    end
  end

  // Next-state for priority owner, starvation/burst counters and read owner.
  // The burst limit is judged on the post-grant count so the CPU regains
  // priority right after the DBG_MAX-th debug grant rather than one later.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = '0;
    burst_cnt_d = burst_cnt_q;
    dbg_waiting = bus.dbg_req & ~dbg_gnt;

    if (dbg_waiting) begin
      wait_cnt_d = (wait_cnt_q == WAIT_LAST) ? wait_cnt_q : wait_cnt_q + 1'b1;
    end

    case (state_q)
      CPU_PRI: begin
        burst_cnt_d = '0;
        if (dbg_waiting && (wait_cnt_q == WAIT_LAST)) begin
          state_d    = DBG_PRI;
          wait_cnt_d = '0;
        end
      end
      DBG_PRI: begin
        if (dbg_gnt && (burst_cnt_q != BURST_MAX)) begin
          burst_cnt_d = burst_cnt_q + 1'b1;
        end
        if (!bus.dbg_req || (bus.cpu_req && (burst_cnt_d == BURST_MAX))) begin
          state_d     = CPU_PRI;
          burst_cnt_d = '0;
        end
      end
      default: begin
        state_d     = CPU_PRI;
        burst_cnt_d = '0;
      end
    endcase

    rd_cpu_d = cpu_gnt & ~bus.cpu_we;
    rd_dbg_d = dbg_gnt & ~bus.dbg_we;
  end

  // Register priority state, counters and read owner; active-low sync reset
  // drops any read that was in flight when reset arrived.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= CPU_PRI;
      wait_cnt_q  <= '0;
      burst_cnt_q <= '0;
      rd_cpu_q    <= 1'b0;
      rd_dbg_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      rd_cpu_q    <= rd_cpu_d;
      rd_dbg_q    <= rd_dbg_d;
    end
  end

  assign bus.cpu_gnt   = cpu_gnt;
  assign bus.dbg_gnt   = dbg_gnt;
  assign bus.cpu_stall = bus.cpu_req & ~cpu_gnt;

  assign bus.mem_en    = cpu_gnt | dbg_gnt;
  assign bus.mem_we    = mem_we_d;
  assign bus.mem_addr  = mem_addr_d;
  assign bus.mem_wdata = mem_wdata_d;

  // Read data is shared; only the per-port valid says whose it is. Valids are
  // gated by reset so the first reset cycle cannot leak a stale return.
  assign bus.cpu_rdata  = bus.mem_rdata;
  assign bus.dbg_rdata  = bus.mem_rdata;
  assign bus.cpu_rvalid = rd_cpu_q & rst;
  assign bus.dbg_rvalid = rd_dbg_q & rst;

endmodule
